mem_access_unit: RTL

// - MEM-stage consumer of the EX/MEM control register: memRead, memWrite, maskMode, sext.
// - Turns one load or store into a req/gnt + rvalid data-bus transaction.
// - Aligns store data and byte strobes; extracts and sign- or zero-extends load data.
// - Holds the pipeline with stall until the access completes.

---
 rtl/mem_pkg.sv | 40 ++++
 rtl/mem_lane_align.sv | 37 +++
 rtl/mem_access_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and alignment helpers for the MEM-stage access unit.
package mem_pkg;

  localparam logic [1:0] MASK_B = 2'd0;
  localparam logic [1:0] MASK_H = 2'd1;
  localparam logic [1:0] MASK_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    RESP   = 2'd3
  } state_t;

  // mask_mode 3 falls into the word branch everywhere
  function automatic logic [3:0] strb_gen(input logic [1:0] mode, input logic [1:0] o);
    case (mode)
      MASK_B:  return 4'b0001 << o;
      MASK_H:  return o[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] mode, input logic [1:0] o);
    case (mode)
      MASK_B:  return 1'b0;
      MASK_H:  return o[0];
      default: return o != 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] off_fix(input logic [1:0] mode, input logic [1:0] o);
    case (mode)
      MASK_B:  return o;
      MASK_H:  return {o[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: store replication and strobes, load lane extract and extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_mode,
  input  logic [1:0]  i_off,
  input  logic        i_sext,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_rdata
);

  logic [15:0] w_lane;

  always_comb begin
    w_lane  = 16'(i_rdata >> {i_off, 3'b000});
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    case (i_mode)
      MASK_B: begin
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{i_sext & w_lane[7]}}, w_lane[7:0]};
      end
      MASK_H: begin
        w_lane  = 16'(i_rdata >> {i_off[1], 4'b0000});
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{i_sext & w_lane[15]}}, w_lane[15:0]};
      end
      default: ;
    endcase
  end

  assign o_wstrb = strb_gen(i_mode, i_off);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one req/gnt(+rvalid) bus access per instruction, stalling until done.
// Store 3 cycles, load 4 at zero wait states; MEM_MISALIGN_TRAP_EN adds misalign_fault instead of forcing alignment.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mask_mode,
  input  logic              sext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              stall,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              misalign_fault
`endif
);

  state_t            r_state;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_mode;
  logic [1:0]        r_off;
  logic              r_sext;
  logic [DATA_W-1:0] r_ldata;
  logic              r_lvld;

  logic              w_start;
  logic              w_go;
  logic [3:0]        w_strb;
  logic [DATA_W-1:0] w_wdata_al;
  logic [DATA_W-1:0] w_rdata_ext;

  assign w_start = (mem_read | mem_write) && (r_state == IDLE);

`ifdef MEM_MISALIGN_TRAP_EN
  // A misaligned request never reaches the bus; the pipeline traps instead of stalling.
  assign w_go           = w_start & ~is_misaligned(mask_mode, addr[1:0]);
  assign misalign_fault = w_start &  is_misaligned(mask_mode, addr[1:0]);
`else
  assign w_go = w_start;
`endif

  mem_lane_align u_align (
    .i_mode  (r_mode),
    .i_off   (r_off),
    .i_sext  (r_sext),
    .i_wdata (r_wdata),
    .i_rdata (bus_rdata),
    .o_wdata (w_wdata_al),
    .o_wstrb (w_strb),
    .o_rdata (w_rdata_ext)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_mode  <= MASK_B;
      r_off   <= 2'b00;
      r_sext  <= 1'b0;
      r_ldata <= '0;
      r_lvld  <= 1'b0;
    end else begin
      r_lvld <= 1'b0;
      case (r_state)
        IDLE: if (w_go) begin
          r_addr  <= {addr[ADDR_W-1:2], 2'b00};
          r_wdata <= wdata;
          r_mode  <= mask_mode;
          r_off   <= off_fix(mask_mode, addr[1:0]);
          r_sext  <= sext;
          r_we    <= mem_write;
          r_req   <= 1'b1;
          r_state <= REQ;
        end
        REQ: if (bus_gnt) begin
          r_req   <= 1'b0;
          r_state <= r_we ? RESP : WAIT_R;
        end
        WAIT_R: if (bus_rvalid) begin
          r_ldata <= w_rdata_ext;
          r_lvld  <= 1'b1;
          r_state <= RESP;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus_req    = r_req;
  assign bus_we     = r_we;
  assign bus_addr   = r_addr;
  assign bus_wdata  = w_wdata_al;
  assign bus_wstrb  = r_we ? w_strb : 4'b0000;
  assign stall      = w_go | (r_state == REQ) | (r_state == WAIT_R);
  assign load_data  = r_ldata;
  assign load_valid = r_lvld;

endmodule
